// File: rtl/seq_step_controller_pkg.sv
// rtl/seq_step_controller_pkg.sv - shared FSM state encoding, direction constants and helpers
package seq_step_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD_UP  = 3'd1,
        ST_HOLD_DN  = 3'd2,
        ST_BLANKED  = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_step_controller_key_debounce.sv
// rtl/seq_step_controller_key_debounce.sv - 2-flop synchroniser plus stable-count debounce for one key
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clock,
    input  logic RESET,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain.
    always_ff @(posedge clock or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Flip the level once DEBOUNCE_CYC consecutive samples disagree with it; any agreeing sample restarts.
    always_ff @(posedge clock or posedge RESET) begin
        if (RESET) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync2 != r_level) begin
            if (r_cnt == LAST_CNT) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign level = r_level;

endmodule

// File: rtl/seq_step_controller.sv
// rtl/seq_step_controller.sv - debounced up/down step generator with auto-repeat and blank/clear handshake
module seq_step_controller
    import seq_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 500_000,
    parameter int REPEAT_DELAY_CYC = 25_000_000,
    parameter int REPEAT_RATE_CYC  = 10_000_000
) (
    input  logic clock,
    input  logic RESET,
    input  logic KEY_UP,
    input  logic KEY_DOWN,
    output logic STEP,
    output logic DIR,
    output logic BLANK,
    output logic CLEAR
);
    localparam int RCW = $clog2(max_int(REPEAT_DELAY_CYC, REPEAT_RATE_CYC) + 1);
    localparam logic [RCW-1:0] DELAY_LOAD = RCW'(REPEAT_DELAY_CYC);
    localparam logic [RCW-1:0] RATE_LOAD  = RCW'(REPEAT_RATE_CYC);

    logic           w_up;
    logic           w_dn;
    state_t         r_state;
    state_t         w_next;
    logic [RCW-1:0] r_cnt;
    logic [RCW-1:0] w_cnt;
    logic           w_step;
    logic           w_dir;
    logic           w_blank;
    logic           w_clear;
    logic           r_step;
    logic           r_dir;
    logic           r_blank;
    logic           r_clear;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .clock (clock),
        .RESET (RESET),
        .raw   (KEY_UP),
        .level (w_up)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
        .clock (clock),
        .RESET (RESET),
        .raw   (KEY_DOWN),
        .level (w_dn)
    );

    // State, repeat counter and registered outputs.
    always_ff @(posedge clock or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
            r_dir   <= DIR_DN;
            r_blank <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_step  <= w_step;
            r_dir   <= w_dir;
            r_blank <= w_blank;
            r_clear <= w_clear;
        end
    end

    // Next state: a second key always wins over stepping, and release wins over repeat expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_up && w_dn)  w_next = ST_BLANKED;
                else if (w_up)     w_next = ST_HOLD_UP;
                else if (w_dn)     w_next = ST_HOLD_DN;
            end
            ST_HOLD_UP: begin
                if (w_dn)          w_next = ST_BLANKED;
                else if (!w_up)    w_next = ST_IDLE;
            end
            ST_HOLD_DN: begin
                if (w_up)          w_next = ST_BLANKED;
                else if (!w_dn)    w_next = ST_IDLE;
            end
            ST_BLANKED: begin
                if (w_up ^ w_dn)   w_next = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!w_up && !w_dn) w_next = ST_IDLE;
            end
            default:               w_next = ST_IDLE;
        endcase
    end

    // Outputs and repeat counter; the counter parks at 0 whenever we are not holding a key.
    always_comb begin
        w_step  = 1'b0;
        w_clear = 1'b0;
        w_dir   = r_dir;
        w_cnt   = '0;
        w_blank = (w_next == ST_BLANKED);
        case (r_state)
            ST_IDLE: begin
                if (w_next == ST_HOLD_UP) begin
                    w_step = 1'b1;
                    w_dir  = DIR_UP;
                    w_cnt  = DELAY_LOAD;
                end else if (w_next == ST_HOLD_DN) begin
                    w_step = 1'b1;
                    w_dir  = DIR_DN;
                    w_cnt  = DELAY_LOAD;
                end
            end
            ST_HOLD_UP, ST_HOLD_DN: begin
                if (w_next == r_state) begin
                    if (r_cnt <= RCW'(1)) begin
                        w_step = 1'b1;
                        w_cnt  = RATE_LOAD;
                    end else begin
                        w_cnt  = r_cnt - RCW'(1);
                    end
                end
            end
            ST_BLANKED: begin
                if (w_next == ST_WAIT_REL) w_clear = 1'b1;
            end
            default: begin
                w_step = 1'b0;
            end
        endcase
    end

    assign STEP  = r_step;
    assign DIR   = r_dir;
    assign BLANK = r_blank;
    assign CLEAR = r_clear;

endmodule
